mem_write_buffer: RTL and testbench

- Posted-write buffer between the sv32 cache/MMU memory port (mem_* master) and external memory.
- Writes from the cache are acknowledged once queued in a FIFO and drained to memory in the background.
- Reads are ordered against queued writes to the same word, so the cache never sees stale data.
- Cuts write-back and write-through stall time on cache misses and replacements.

---
 rtl/mem_write_buffer.sv | 192 +++++++++++++++++++
 tb/tb_mem_write_buffer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the cache memory port and external memory.
// Build option: define MEM_WB_READ_FORWARD_EN to serve full-word read hazards from the buffer.
module mem_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 34,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [3:0]    up_wstrb,
  input  logic [AW-1:0] up_addr,
  input  logic [31:0]   up_wdata,
  output logic [31:0]   up_rdata,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          flush,
  output logic          flush_done,
  output logic [PTR_W:0] occupancy,
  output logic          full
);

  localparam int unsigned WAW = AW - 2;

  typedef enum logic [1:0] {UIdle, UAck, URd} ustate_e;
  typedef enum logic [1:0] {MIdle, MWr, MRd, MGap} mstate_e;

  ustate_e u_q, u_d;
  mstate_e m_q, m_d;

  logic [WAW-1:0]   ent_addr_q [DEPTH];
  logic [3:0]       ent_strb_q [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_vld_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [3:0]    mstrb_q, mstrb_d;
  logic [31:0]   mdata_q, mdata_d;

  logic [WAW-1:0]   up_waddr;
  logic             is_wr, is_rd, push, pop, rd_hs, hazard;
  logic [PTR_W-1:0] idx;
  logic             unused_addr_lsb;
`ifdef MEM_WB_READ_FORWARD_EN
  logic             fwd_hit;
  logic [31:0]      fwd_data;
`endif

  assign up_waddr        = up_addr[AW-1:2];
  assign unused_addr_lsb = ^up_addr[1:0];
  assign is_wr           = up_valid && (up_wstrb != 4'h0);
  assign is_rd           = up_valid && (up_wstrb == 4'h0);
  assign full            = (count_q == (PTR_W+1)'(DEPTH));
  assign push            = (u_q == UIdle) && is_wr && !full && !flush;
  assign pop             = (m_q == MWr) && mem_ready;
  assign rd_hs           = (m_q == MRd) && mem_ready;

  // Scan oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    hazard = 1'b0;
    idx    = '0;
`ifdef MEM_WB_READ_FORWARD_EN
    fwd_hit  = 1'b0;
    fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (ent_vld_q[idx] && (ent_addr_q[idx] == up_waddr)) begin
        hazard = 1'b1;
`ifdef MEM_WB_READ_FORWARD_EN
        fwd_hit  = (ent_strb_q[idx] == 4'hF);
        fwd_data = ent_data_q[idx];
`endif
      end
    end
  end

  always_comb begin
    u_d     = u_q;
    rdata_d = rdata_q;
    unique case (u_q)
      UIdle: begin
        if (push) begin
          u_d = UAck;
        end else if (is_rd && !hazard) begin
          u_d = URd;
        end
`ifdef MEM_WB_READ_FORWARD_EN
        else if (is_rd && fwd_hit) begin
          u_d     = UAck;
          rdata_d = fwd_data;
        end
`endif
      end
      UAck: u_d = UIdle;
      URd: begin
        if (rd_hs) begin
          rdata_d = mem_rdata;
          u_d     = UAck;
        end
      end
      default: u_d = UIdle;
    endcase
  end

  // A pending read wins over draining; request fields are frozen until mem_ready.
  always_comb begin
    m_d     = m_q;
    maddr_d = maddr_q;
    mstrb_d = mstrb_q;
    mdata_d = mdata_q;
    unique case (m_q)
      MIdle: begin
        if (u_q == URd) begin
          m_d     = MRd;
          maddr_d = {up_waddr, 2'b00};
          mstrb_d = 4'h0;
          mdata_d = '0;
        end else if (count_q != '0) begin
          m_d     = MWr;
          maddr_d = {ent_addr_q[rd_ptr_q], 2'b00};
          mstrb_d = ent_strb_q[rd_ptr_q];
          mdata_d = ent_data_q[rd_ptr_q];
        end
      end
      MWr, MRd: if (mem_ready) m_d = MGap;
      MGap:     m_d = MIdle;
      default:  m_d = MIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      u_q       <= UIdle;
      m_q       <= MIdle;
      rdata_q   <= '0;
      maddr_q   <= '0;
      mstrb_q   <= '0;
      mdata_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ent_vld_q <= '0;
    end else begin
      u_q     <= u_d;
      m_q     <= m_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      mstrb_q <= mstrb_d;
      mdata_q <= mdata_d;
      if (push) begin
        ent_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        ent_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q            <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= up_waddr;
      ent_strb_q[wr_ptr_q] <= up_wstrb;
      ent_data_q[wr_ptr_q] <= up_wdata;
    end
  end

  assign up_ready   = (u_q == UAck);
  assign up_rdata   = rdata_q;
  assign mem_valid  = (m_q == MWr) || (m_q == MRd);
  assign mem_addr   = maddr_q;
  assign mem_wstrb  = mstrb_q;
  assign mem_wdata  = mdata_q;
  assign occupancy  = count_q;
  assign flush_done = flush && (count_q == '0);

endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboard bench for mem_write_buffer: stimulus queues expected responses, monitors compare.
module tb_mem_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 34;

  logic          clk = 1'b0;
  logic          reset;
  logic          up_valid, up_ready;
  logic [3:0]    up_wstrb;
  logic [AW-1:0] up_addr;
  logic [31:0]   up_wdata, up_rdata;
  logic          mem_valid, mem_ready;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          flush, flush_done, full;
  logic [2:0]    occupancy;

  mem_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .up_valid(up_valid), .up_ready(up_ready), .up_wstrb(up_wstrb), .up_addr(up_addr),
    .up_wdata(up_wdata), .up_rdata(up_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .flush(flush), .flush_done(flush_done), .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_rd; logic [31:0] data;} up_exp_t;
  typedef struct {logic [AW-1:0] addr; logic [3:0] strb; logic [31:0] data;} mem_exp_t;

  up_exp_t  up_q[$];
  mem_exp_t mem_q[$];
  logic [31:0] mem_arr [logic [AW-1:0]];

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 0;
  bit mem_stall = 1'b0;
  int wait_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [AW-1:0] a);
    logic [15:0] lo;
    if (mem_arr.exists(a)) return mem_arr[a];
    lo = a[15:0];
    return {16'hDEAD, lo};
  endfunction

  // Memory: ready is registered from valid after mem_lat extra cycles.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_ready || reset) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end else if (mem_valid && !mem_stall) begin
        if (wait_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
          mem_rdata = mem_read(mem_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Memory-side monitor: order, address, strobes and data of every transfer.
  initial begin
    mem_exp_t e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (!reset && mem_valid && mem_ready) begin
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected mem transfer: got addr %0h strb %0h expected none",
                   mem_addr, mem_wstrb);
        end else begin
          e = mem_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          check("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
          if (e.strb != 4'h0) check("mem_wdata", 64'(mem_wdata), 64'(e.data));
        end
        if (mem_wstrb != 4'h0) begin
          w = mem_read(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_arr[mem_addr] = w;
        end
      end
    end
  end

  // Upstream monitor: every ready pops one expectation; reads compare data.
  initial begin
    up_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && up_ready) begin
        if (up_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected up_ready: got 1 expected 0");
        end else begin
          e = up_q.pop_front();
          if (e.is_rd) check("up_rdata", 64'(up_rdata), 64'(e.data));
        end
      end
    end
  end

  task automatic exp_mem(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d);
    mem_exp_t e;
    e.addr = a; e.strb = s; e.data = d;
    mem_q.push_back(e);
  endtask

  // Called just after a rising edge.
  task automatic start_req(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d,
                           input logic [31:0] exp_rd);
    up_exp_t e;
    e.is_rd = (s == 4'h0);
    e.data  = exp_rd;
    up_q.push_back(e);
    up_addr = a; up_wstrb = s; up_wdata = d; up_valid = 1'b1;
  endtask

  task automatic wait_ack(input int exp_lat);
    int n;
    bit got;
    n = 0; got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (up_ready) begin got = 1'b1; break; end
      n++;
    end
    check("up_ready seen", 64'(got), 64'd1);
    if (got && exp_lat >= 0) check("ack latency", 64'(n), 64'(exp_lat));
    @(posedge clk); #1;
    up_valid = 1'b0;
  endtask

  task automatic req(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d,
                     input logic [31:0] exp_rd, input int exp_lat);
    start_req(a, s, d, exp_rd);
    wait_ack(exp_lat);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (occupancy == 3'd0 && !mem_valid) begin done = 1'b1; break; end
    end
    check("drain finished", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw, done;
    logic prev_fd;
    reset = 1'b1; up_valid = 1'b0; up_wstrb = '0; up_addr = '0; up_wdata = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset up_ready", 64'(up_ready), 64'd0);
    check("reset mem_valid", 64'(mem_valid), 64'd0);
    check("reset occupancy", 64'(occupancy), 64'd0);
    check("reset full", 64'(full), 64'd0);
    check("reset up_rdata", 64'(up_rdata), 64'd0);
    @(posedge clk); #1;

    // Posted write acknowledged before the slow memory completes.
    mem_lat = 3;
    exp_mem(34'h1000, 4'hF, 32'h11223344);
    req(34'h1000, 4'hF, 32'h11223344, 32'h0, 1);
    check("occupancy after post", 64'(occupancy), 64'd1);
    wait_drain();
    check("occupancy drained", 64'(occupancy), 64'd0);

    // Fill with memory stalled; the fifth write waits for a free slot.
    mem_stall = 1'b1;
    exp_mem(34'h2000, 4'hF, 32'hA0002000);
    exp_mem(34'h3000, 4'hF, 32'hA0003000);
    exp_mem(34'h4000, 4'hF, 32'hA0004000);
    exp_mem(34'h5000, 4'hF, 32'hA0005000);
    exp_mem(34'h7000, 4'hF, 32'hA0007000);
    req(34'h2000, 4'hF, 32'hA0002000, 32'h0, 1);
    req(34'h3000, 4'hF, 32'hA0003000, 32'h0, 1);
    req(34'h4000, 4'hF, 32'hA0004000, 32'h0, 1);
    req(34'h5000, 4'hF, 32'hA0005000, 32'h0, 1);
    check("full at depth", 64'(full), 64'd1);
    check("occupancy at depth", 64'(occupancy), 64'd4);
    start_req(34'h7000, 4'hF, 32'hA0007000, 32'h0);
    saw = 1'b0;
    repeat (6) begin @(negedge clk); if (up_ready) saw = 1'b1; end
    check("no ack while full", 64'(saw), 64'd0);
    mem_lat = 0;
    mem_stall = 1'b0;
    wait_ack(-1);
    wait_drain();

    // Read after a buffered write to the same word must see the new data.
    mem_lat = 2;
    exp_mem(34'h2000, 4'hF, 32'hAABBCCDD);
    exp_mem(34'h2000, 4'h0, 32'h0);
    req(34'h2000, 4'hF, 32'hAABBCCDD, 32'h0, 1);
    req(34'h2000, 4'h0, 32'h0, 32'hAABBCCDD, -1);
    wait_drain();

    // Non-matching read overtakes the queued 0x3000 write.
    mem_stall = 1'b1;
    exp_mem(34'h9000, 4'hF, 32'h00009000);
    exp_mem(34'h6000, 4'h0, 32'h0);
    exp_mem(34'h3000, 4'hF, 32'h00003000);
    req(34'h9000, 4'hF, 32'h00009000, 32'h0, 1);
    req(34'h3000, 4'hF, 32'h00003000, 32'h0, 1);
    mem_lat = 3;
    mem_stall = 1'b0;
    req(34'h6000, 4'h0, 32'h0, 32'hDEAD6000, -1);
    wait_drain();

    // Full-word hazard: forwarded when enabled, drained otherwise.
    mem_lat = 3;
    exp_mem(34'h4000, 4'hF, 32'h12345678);
`ifdef MEM_WB_READ_FORWARD_EN
    req(34'h4000, 4'hF, 32'h12345678, 32'h0, 1);
    req(34'h4000, 4'h0, 32'h0, 32'h12345678, 1);
`else
    exp_mem(34'h4000, 4'h0, 32'h0);
    req(34'h4000, 4'hF, 32'h12345678, 32'h0, 1);
    req(34'h4000, 4'h0, 32'h0, 32'h12345678, -1);
`endif
    wait_drain();
    // Partial-strobe hazard always drains and merges in memory.
    exp_mem(34'h4000, 4'h3, 32'hCAFEBEEF);
    exp_mem(34'h4000, 4'h0, 32'h0);
    req(34'h4000, 4'h3, 32'hCAFEBEEF, 32'h0, 1);
    req(34'h4000, 4'h0, 32'h0, 32'h1234BEEF, -1);
    wait_drain();

    // Flush blocks new writes and reports completion when empty.
    mem_stall = 1'b1;
    exp_mem(34'hA000, 4'hF, 32'h0000A0A0);
    exp_mem(34'hB000, 4'hF, 32'h0000B0B0);
    exp_mem(34'hC000, 4'hF, 32'h0000C0C0);
    exp_mem(34'hD000, 4'hF, 32'h0000D0D0);
    req(34'hA000, 4'hF, 32'h0000A0A0, 32'h0, 1);
    req(34'hB000, 4'hF, 32'h0000B0B0, 32'h0, 1);
    req(34'hC000, 4'hF, 32'h0000C0C0, 32'h0, 1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_done while busy", 64'(flush_done), 64'd0);
    @(posedge clk); #1;
    start_req(34'hD000, 4'hF, 32'h0000D0D0, 32'h0);
    saw = 1'b0;
    repeat (5) begin @(negedge clk); if (up_ready) saw = 1'b1; end
    check("no ack during flush", 64'(saw), 64'd0);
    check("occupancy during flush", 64'(occupancy), 64'd3);
    mem_lat = 0;
    mem_stall = 1'b0;
    done = 1'b0;
    prev_fd = flush_done;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (occupancy == 3'd0) begin done = 1'b1; break; end
      prev_fd = flush_done;
    end
    check("flush drained", 64'(done), 64'd1);
    check("flush_done at empty", 64'(flush_done), 64'd1);
    check("flush_done before empty", 64'(prev_fd), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    wait_ack(-1);
    wait_drain();

    // Reset while a write is stuck on the memory port discards everything.
    mem_stall = 1'b1;
    req(34'hE000, 4'hF, 32'h0000E0E0, 32'h0, 1);
    req(34'hF000, 4'hF, 32'h0000F0F0, 32'h0, 1);
    check("mem_valid before reset", 64'(mem_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("occupancy after reset", 64'(occupancy), 64'd0);
    check("mem_valid after reset", 64'(mem_valid), 64'd0);
    check("full after reset", 64'(full), 64'd0);
    reset = 1'b0;
    mem_stall = 1'b0;
    repeat (10) @(negedge clk);
    check("mem expectations left", 64'(mem_q.size()), 64'd0);
    check("up expectations left", 64'(up_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
